// File: rtl/popcount_stream_accumulator.sv
// popcount_stream_accumulator
// Counts 1s and 0s across a multi-word frame on a valid/ready input stream.
// The two-stage pipeline first registers the popcount of each word.
// It then accumulates per-frame totals.
// Totals are presented on a valid/ready result port.
// Optional feature: define POPCNT_SATURATE_EN to make the frame counters saturate
// on overflow. When it is undefined, the counters wrap. Overflow is reported either way.

module popcount_stream_accumulator #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  ones_total,
  output logic [CNT_WIDTH-1:0]  zeros_total,
  output logic [CNT_WIDTH-1:0]  frame_words,
  output logic                  overflow
);

  localparam int PC_W  = $clog2(DATA_WIDTH + 1);
  // The sums are wide enough to hold a full counter plus one word's contribution.
  // Any bit at or above CNT_WIDTH therefore marks an overflow.
  localparam int EXT_W = ((PC_W > CNT_WIDTH) ? PC_W : CNT_WIDTH) + 1;
  localparam logic [EXT_W-1:0] DW_EXT  = EXT_W'(DATA_WIDTH);
  localparam logic [EXT_W-1:0] ONE_EXT = EXT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [PC_W-1:0]      in_pc;
  logic [PC_W-1:0]      s1_pc;
  logic                 s1_valid;
  logic                 s1_last;

  logic [CNT_WIDTH-1:0] acc_ones;
  logic [CNT_WIDTH-1:0] acc_zeros;
  logic [CNT_WIDTH-1:0] acc_words;
  logic                 acc_ovf;

  logic [EXT_W-1:0]     ones_sum;
  logic [EXT_W-1:0]     zeros_sum;
  logic [EXT_W-1:0]     words_sum;
  logic                 ones_of;
  logic                 zeros_of;
  logic                 words_of;
  logic [CNT_WIDTH-1:0] ones_next;
  logic [CNT_WIDTH-1:0] zeros_next;
  logic [CNT_WIDTH-1:0] words_next;
  logic                 ovf_next;

  logic                 accept;
  logic                 frame_end;
  logic                 result_taken;

  // Input is blocked from the moment the last word enters S1 until the result is taken.
  assign in_ready     = (state != DONE) && !(s1_valid && s1_last);
  assign accept       = in_valid && in_ready;
  assign frame_end    = s1_valid && s1_last;
  assign result_taken = out_valid && out_ready;

  // Combinational popcount of the incoming word
  always_comb begin
    in_pc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      in_pc = in_pc + PC_W'(in_data[i]);
    end
  end

  // Stage 1: capture the word's popcount and its last flag on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_pc    <= '0;
      s1_last  <= 1'b0;
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_pc    <= in_pc;
      s1_last  <= in_last;
      s1_valid <= 1'b1;
    end else begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 arithmetic: compute updated counters and detect overflow
  always_comb begin
    ones_sum   = EXT_W'(acc_ones) + EXT_W'(s1_pc);
    zeros_sum  = EXT_W'(acc_zeros) + (DW_EXT - EXT_W'(s1_pc));
    words_sum  = EXT_W'(acc_words) + ONE_EXT;
    ones_of    = |ones_sum[EXT_W-1:CNT_WIDTH];
    zeros_of   = |zeros_sum[EXT_W-1:CNT_WIDTH];
    words_of   = |words_sum[EXT_W-1:CNT_WIDTH];
    ones_next  = ones_sum[CNT_WIDTH-1:0];
    zeros_next = zeros_sum[CNT_WIDTH-1:0];
    words_next = words_sum[CNT_WIDTH-1:0];
`ifdef POPCNT_SATURATE_EN
    // A counter already at its maximum stays there, because further sums overflow again.
    if (ones_of)  ones_next  = '1;
    if (zeros_of) zeros_next = '1;
    if (words_of) words_next = '1;
`endif
    ovf_next   = acc_ovf | ones_of | zeros_of | words_of;
  end

  // Stage 2 accumulators: update on every S1 word and clear when the frame closes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_ones  <= '0;
      acc_zeros <= '0;
      acc_words <= '0;
      acc_ovf   <= 1'b0;
    end else if (frame_end) begin
      acc_ones  <= '0;
      acc_zeros <= '0;
      acc_words <= '0;
      acc_ovf   <= 1'b0;
    end else if (s1_valid) begin
      acc_ones  <= ones_next;
      acc_zeros <= zeros_next;
      acc_words <= words_next;
      acc_ovf   <= ovf_next;
    end
  end

  // Result registers: load at frame end, then hold the values past the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_total  <= '0;
      zeros_total <= '0;
      frame_words <= '0;
      overflow    <= 1'b0;
      out_valid   <= 1'b0;
    end else if (frame_end) begin
      ones_total  <= ones_next;
      zeros_total <= zeros_next;
      frame_words <= words_next;
      overflow    <= ovf_next;
      out_valid   <= 1'b1;
    end else if (result_taken) begin
      out_valid   <= 1'b0;
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A single-word frame goes straight from IDLE to DONE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (frame_end) begin
          state_next = DONE;
        end else if (accept && !in_last) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (frame_end) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (result_taken) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_popcount_stream_accumulator.sv
// Directed testbench for popcount_stream_accumulator.
// Two instances share one input stream: dut (8-bit words, 16-bit counters) and
// dut4 (8-bit words, 4-bit counters).
// dut4 is used for the overflow case. Its expected ones total depends on
// POPCNT_SATURATE_EN.

module tb_popcount_stream_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [15:0] ones_total;
  logic [15:0] zeros_total;
  logic [15:0] frame_words;
  logic       overflow;

  logic       in_ready4;
  logic       out_valid4;
  logic [3:0] ones_total4;
  logic [3:0] zeros_total4;
  logic [3:0] frame_words4;
  logic       overflow4;

  int vectors;
  int miscompares;
  logic [31:0] exp_sat_ones;

  popcount_stream_accumulator #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .ones_total(ones_total), .zeros_total(zeros_total),
    .frame_words(frame_words), .overflow(overflow)
  );

  popcount_stream_accumulator #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid4), .out_ready(out_ready),
    .ones_total(ones_total4), .zeros_total(zeros_total4),
    .frame_words(frame_words4), .overflow(overflow4)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l);
    in_valid = v;
    in_data  = d;
    in_last  = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus sequence
  initial begin
    vectors     = 0;
    miscompares = 0;
`ifdef POPCNT_SATURATE_EN
    exp_sat_ones = 32'd15;
`else
    exp_sat_ones = 32'd0;
`endif
    rst_n     = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_ones", ones_total, 0);
    checkOutput("rst_zeros", zeros_total, 0);
    checkOutput("rst_words", frame_words, 0);
    checkOutput("rst_overflow", overflow, 0);
    stepClk();

    // Test 1: three-word frame 0xFF, 0x0F, 0x00(last)
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("t1_ready_w0", in_ready, 1);
    stepClk();
    applyStimulus(1'b1, 8'h0F, 1'b0);
    stepClk();
    applyStimulus(1'b1, 8'h00, 1'b1);
    stepClk();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t1_valid_n1", out_valid, 0);
    checkOutput("t1_ready_blocked", in_ready, 0);
    stepClk();
    checkOutput("t1_valid_n2", out_valid, 1);
    checkOutput("t1_ones", ones_total, 12);
    checkOutput("t1_zeros", zeros_total, 12);
    checkOutput("t1_words", frame_words, 3);
    checkOutput("t1_overflow", overflow, 0);
    stepClk();
    checkOutput("t1_valid_drop", out_valid, 0);
    checkOutput("t1_ready_back", in_ready, 1);
    checkOutput("t1_ones_held", ones_total, 12);

    // Test 2: single-word frame 0xA5
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'hA5, 1'b1);
    stepClk();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t2_ready_blocked", in_ready, 0);
    stepClk();
    checkOutput("t2_valid", out_valid, 1);
    checkOutput("t2_ones", ones_total, 4);
    checkOutput("t2_zeros", zeros_total, 4);
    checkOutput("t2_words", frame_words, 1);

    // Test 3: result held while out_ready=0 and in_valid=1
    applyStimulus(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkOutput("t3_ready_low", in_ready, 0);
      checkOutput("t3_valid_held", out_valid, 1);
      checkOutput("t3_ones_held", ones_total, 4);
      checkOutput("t3_zeros_held", zeros_total, 4);
      checkOutput("t3_words_held", frame_words, 1);
    end
    out_ready = 1'b1;
    stepClk();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t3_valid_drop", out_valid, 0);
    checkOutput("t3_ready_back", in_ready, 1);
    checkOutput("t3_ones_kept", ones_total, 4);

    // Test 4: overflow on the 4-bit counter instance with frame 0xFF, 0xFF(last)
    applyStimulus(1'b1, 8'hFF, 1'b0);
    stepClk();
    applyStimulus(1'b1, 8'hFF, 1'b1);
    stepClk();
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepClk();
    checkOutput("t4_valid4", out_valid4, 1);
    checkOutput("t4_overflow4", overflow4, 1);
    checkOutput("t4_ones4", ones_total4, exp_sat_ones);
    checkOutput("t4_zeros4", zeros_total4, 0);
    checkOutput("t4_words4", frame_words4, 2);
    checkOutput("t4_ones16", ones_total, 16);
    checkOutput("t4_overflow16", overflow, 0);
    stepClk();
    checkOutput("t4_valid_drop", out_valid, 0);

    // Test 5: asynchronous reset mid-frame, then a clean single-word frame
    applyStimulus(1'b1, 8'hFF, 1'b0);
    stepClk();
    applyStimulus(1'b1, 8'hFF, 1'b0);
    stepClk();
    applyStimulus(1'b0, 8'h00, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_valid", out_valid, 0);
    checkOutput("t5_rst_ones", ones_total, 0);
    checkOutput("t5_rst_zeros", zeros_total, 0);
    checkOutput("t5_rst_words", frame_words, 0);
    checkOutput("t5_rst_overflow4", overflow4, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    stepClk();
    applyStimulus(1'b1, 8'h01, 1'b1);
    stepClk();
    applyStimulus(1'b0, 8'h00, 1'b0);
    stepClk();
    checkOutput("t5_valid", out_valid, 1);
    checkOutput("t5_ones", ones_total, 1);
    checkOutput("t5_zeros", zeros_total, 7);
    checkOutput("t5_words", frame_words, 1);
    stepClk();

    // Test 6: back-to-back frames with in_valid held high
    applyStimulus(1'b1, 8'h03, 1'b0);
    stepClk();
    applyStimulus(1'b1, 8'h07, 1'b1);
    stepClk();
    applyStimulus(1'b1, 8'hF0, 1'b1);
    checkOutput("t6_ready_gap", in_ready, 0);
    stepClk();
    checkOutput("t6a_valid", out_valid, 1);
    checkOutput("t6a_ones", ones_total, 5);
    checkOutput("t6a_zeros", zeros_total, 11);
    checkOutput("t6a_words", frame_words, 2);
    checkOutput("t6a_ready_done", in_ready, 0);
    stepClk();
    checkOutput("t6_valid_drop", out_valid, 0);
    checkOutput("t6b_ready_first", in_ready, 1);
    stepClk();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t6b_ready_blocked", in_ready, 0);
    stepClk();
    checkOutput("t6b_valid", out_valid, 1);
    checkOutput("t6b_ones", ones_total, 4);
    checkOutput("t6b_zeros", zeros_total, 4);
    checkOutput("t6b_words", frame_words, 1);
    stepClk();
    checkOutput("t6b_valid_drop", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
